keypad_entry9999: RTL and testbench

Scans a 4x4 active-low matrix keypad, debounces key presses and assembles up to four decimal digits into a value 0..9999. It is the input end of the board's 4-digit numeric UI. The live entry is presented as 14-bit binary, directly consumable by the existing 4-digit 7-segment decoder. A committed value is published with a one-cycle strobe.

---
 rtl/keypad_pkg.sv | 52 +++++
 rtl/bcd4_to_bin.sv | 14 +
 rtl/keypad_entry9999.sv | 145 ++++++++++++++
 tb/tb_keypad_entry9999.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and key codes for the 4x4 keypad numeric entry block.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_RELEASE
  } state_t;

  localparam logic [3:0] KEY_0     = 4'd0;
  localparam logic [3:0] KEY_1     = 4'd1;
  localparam logic [3:0] KEY_2     = 4'd2;
  localparam logic [3:0] KEY_3     = 4'd3;
  localparam logic [3:0] KEY_4     = 4'd4;
  localparam logic [3:0] KEY_5     = 4'd5;
  localparam logic [3:0] KEY_6     = 4'd6;
  localparam logic [3:0] KEY_7     = 4'd7;
  localparam logic [3:0] KEY_8     = 4'd8;
  localparam logic [3:0] KEY_9     = 4'd9;
  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_BKSP  = 4'hB;
  localparam logic [3:0] KEY_CLEAR = 4'hC;
  localparam logic [3:0] KEY_NONE  = 4'hF;

  // *, # and D have no function and map to KEY_NONE.
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    key_map = KEY_NONE;
    case ({row, col})
      4'h0: key_map = KEY_1;
      4'h1: key_map = KEY_2;
      4'h2: key_map = KEY_3;
      4'h3: key_map = KEY_ENTER;
      4'h4: key_map = KEY_4;
      4'h5: key_map = KEY_5;
      4'h6: key_map = KEY_6;
      4'h7: key_map = KEY_BKSP;
      4'h8: key_map = KEY_7;
      4'h9: key_map = KEY_8;
      4'hA: key_map = KEY_9;
      4'hB: key_map = KEY_CLEAR;
      4'hC: key_map = KEY_NONE;
      4'hD: key_map = KEY_0;
      4'hE: key_map = KEY_NONE;
      4'hF: key_map = KEY_NONE;
    endcase
  endfunction

  function automatic logic [3:0] col_drive(input logic [1:0] col);
    col_drive = ~(4'b0001 << col);
  endfunction

endpackage

// File: rtl/bcd4_to_bin.sv
// Combinational conversion of four packed BCD digits (d3 in the top nibble) to binary 0..9999.
module bcd4_to_bin
  import keypad_pkg::*;
(
  input  logic [15:0] bcd,
  output logic [13:0] bin
);

  assign bin = 14'(bcd[15:12]) * 14'd1000
             + 14'(bcd[11:8])  * 14'd100
             + 14'(bcd[7:4])   * 14'd10
             + 14'(bcd[3:0]);

endmodule

// File: rtl/keypad_entry9999.sv
// 4x4 keypad scanner with debounce, assembling up to four decimal digits.
// Optional backspace on key B when KEYPAD_BACKSPACE_EN is defined.
module keypad_entry9999
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 10
) (
  input  logic        clk,
  input  logic        rst_a,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  output logic [13:0] value,
  output logic [2:0]  digit_count,
  output logic        entered,
  output logic [13:0] entered_value
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE - 1);

  logic [3:0]       row_meta, row_sync;
  state_t           state;
  logic [1:0]       col, key_row, low_row;
  logic [DIV_W-1:0] div_cnt;
  logic [DEB_W-1:0] deb_cnt;
  logic [15:0]      digits;
  logic [3:0]       key;
  logic             any_low;

  always_ff @(posedge clk) begin
    if (!rst_a) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row_in;
      row_sync <= row_meta;
    end
  end

  assign any_low = ~&row_sync;
  assign low_row = !row_sync[0] ? 2'd0 :
                   !row_sync[1] ? 2'd1 :
                   !row_sync[2] ? 2'd2 : 2'd3;
  assign key     = key_map(key_row, col);

  bcd4_to_bin u_bcd (
    .bcd (digits),
    .bin (value)
  );

  // The column stays driven through DEBOUNCE and RELEASE so the latched key is watched directly.
  always_ff @(posedge clk) begin
    if (!rst_a) begin
      state         <= ST_SCAN;
      col           <= 2'd0;
      col_out       <= 4'b1110;
      key_row       <= 2'd0;
      div_cnt       <= '0;
      deb_cnt       <= '0;
      digits        <= 16'd0;
      digit_count   <= 3'd0;
      entered       <= 1'b0;
      entered_value <= 14'd0;
    end else begin
      entered <= 1'b0;
      case (state)
        ST_SCAN: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (any_low) begin
              key_row <= low_row;
              deb_cnt <= '0;
              state   <= ST_DEBOUNCE;
            end else begin
              col     <= col + 2'd1;
              col_out <= col_drive(col + 2'd1);
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        ST_DEBOUNCE: begin
          if (!row_sync[key_row]) begin
            if (deb_cnt == DEB_LAST) begin
              deb_cnt <= '0;
              state   <= ST_RELEASE;
              case (key)
                KEY_ENTER: begin
                  entered       <= 1'b1;
                  entered_value <= value;
                  digits        <= 16'd0;
                  digit_count   <= 3'd0;
                end
                KEY_CLEAR: begin
                  digits      <= 16'd0;
                  digit_count <= 3'd0;
                end
`ifdef KEYPAD_BACKSPACE_EN
                KEY_BKSP: begin
                  if (digit_count != 3'd0) begin
                    digits      <= {4'd0, digits[15:4]};
                    digit_count <= digit_count - 3'd1;
                  end
                end
`endif
                default: begin
                  if (key <= KEY_9 && digit_count < 3'd4) begin
                    digits      <= {digits[11:0], key};
                    digit_count <= digit_count + 3'd1;
                  end
                end
              endcase
            end else begin
              deb_cnt <= deb_cnt + 1'b1;
            end
          end else begin
            deb_cnt <= '0;
            state   <= ST_SCAN;
            col     <= col + 2'd1;
            col_out <= col_drive(col + 2'd1);
          end
        end
        ST_RELEASE: begin
          if (!any_low) begin
            if (deb_cnt == DEB_LAST) begin
              deb_cnt <= '0;
              state   <= ST_SCAN;
              col     <= col + 2'd1;
              col_out <= col_drive(col + 2'd1);
            end else begin
              deb_cnt <= deb_cnt + 1'b1;
            end
          end else begin
            deb_cnt <= '0;
          end
        end
        default: state <= ST_SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_entry9999.sv
// Randomized and directed bench for keypad_entry9999 against a digit-queue reference model.
module tb_keypad_entry9999;

  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 8;

  logic        clk = 1'b0;
  logic        rst_a;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [13:0] value;
  logic [2:0]  digit_count;
  logic        entered;
  logic [13:0] entered_value;

  logic [15:0] pressed;
  int tests = 0;
  int errors = 0;
  int strobes = 0;
  int exp_strobes = 0;
  int exp_ev = 0;
  int digs[$];
  bit prev_ent = 1'b0;

  // Printed keypad layout; 10=A 11=B 12=C 13=D 14=* 15=#.
  int keymap[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

  keypad_entry9999 #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk           (clk),
    .rst_a         (rst_a),
    .row_in        (row_in),
    .col_out       (col_out),
    .value         (value),
    .digit_count   (digit_count),
    .entered       (entered),
    .entered_value (entered_value)
  );

  always #5 clk = ~clk;

  // A held key shorts its row to its column only while that column is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  task automatic checkOutput(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_a) begin
      prev_ent = 1'b0;
    end else begin
      if (prev_ent) begin
        checkOutput("entered_one_cycle", int'(entered), 0);
        checkOutput("value_after_enter", int'(value), 0);
      end
      if (entered) strobes++;
      prev_ent = entered;
    end
  end

  function automatic int model_value();
    int v = 0;
    foreach (digs[i]) v = v * 10 + digs[i];
    return v;
  endfunction

  task automatic model_key(input int k);
    if (k <= 9) begin
      if (digs.size() < 4) digs.push_back(k);
    end else if (k == 10) begin
      exp_strobes++;
      exp_ev = model_value();
      digs.delete();
    end else if (k == 12) begin
      digs.delete();
    end
`ifdef KEYPAD_BACKSPACE_EN
    else if (k == 11) begin
      if (digs.size() > 0) void'(digs.pop_back());
    end
`endif
  endtask

  task automatic checkState(input string tag);
    @(negedge clk);
    checkOutput({tag, "_value"}, int'(value), model_value());
    checkOutput({tag, "_count"}, int'(digit_count), digs.size());
    checkOutput({tag, "_entered_value"}, int'(entered_value), exp_ev);
    checkOutput({tag, "_strobes"}, strobes, exp_strobes);
  endtask

  task automatic applyStimulus(input int idx, input int hold);
    pressed[idx] = 1'b1;
    repeat (hold) @(posedge clk);
    pressed = 16'd0;
    repeat (30) @(posedge clk);
    model_key(keymap[idx]);
  endtask

  task automatic pressKey(input int k);
    int idx = 0;
    for (int i = 0; i < 16; i++) if (keymap[i] == k) idx = i;
    applyStimulus(idx, 45);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_col_out"}, int'(col_out), 14);
    checkOutput({tag, "_value"}, int'(value), 0);
    checkOutput({tag, "_count"}, int'(digit_count), 0);
    checkOutput({tag, "_entered"}, int'(entered), 0);
    checkOutput({tag, "_entered_value"}, int'(entered_value), 0);
  endtask

  initial begin
    int run;
    bit hit;
    rst_a   = 1'b0;
    pressed = 16'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkReset("reset");
    rst_a = 1'b1;

    pressKey(1); checkState("d1");
    pressKey(2); checkState("d12");
    pressKey(3); checkState("d123");
    pressKey(4); checkState("d1234");
    pressKey(5); checkState("full_ignore");
    pressKey(10); checkState("enter");

    // Bouncing 7: contact toggles every 3 cycles, then settles and is held long.
    for (int i = 0; i < 10; i++) begin
      pressed[8] = ~pressed[8];
      repeat (3) @(posedge clk);
    end
    pressed[8] = 1'b1;
    repeat (40) @(posedge clk);
    model_key(7);
    checkState("bounce7");
    repeat (500) @(posedge clk);
    checkState("hold7");
    pressed = 16'd0;
    repeat (30) @(posedge clk);
    checkState("release7");

    pressKey(9); pressKey(0); checkState("d790");
    pressKey(12); checkState("clear");

`ifdef KEYPAD_BACKSPACE_EN
    pressKey(9); pressKey(0); pressKey(11); checkState("bksp9");
    pressKey(11); checkState("bksp0");
    pressKey(11); checkState("bksp_empty");
`else
    pressKey(9); pressKey(11); checkState("b_ignored");
    pressKey(12);
`endif

    // 5 and 8 share column 1; the lower row wins.
    pressed[5] = 1'b1;
    pressed[9] = 1'b1;
    repeat (45) @(posedge clk);
    pressed = 16'd0;
    repeat (30) @(posedge clk);
    model_key(5);
    checkState("simul58");

    pressKey(12); pressKey(4); pressKey(2); checkState("d42");
    pressed[0] = 1'b1;
    run = 0;
    hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      @(negedge clk);
      if (col_out == 4'b1110) run++;
      else run = 0;
      if (run == SCAN_DIV + 3) hit = 1'b1;
    end
    checkOutput("reach_debounce", int'(hit), 1);
    rst_a   = 1'b0;
    pressed = 16'd0;
    @(posedge clk);
    @(negedge clk);
    checkReset("mid_debounce_reset");
    rst_a = 1'b1;
    digs.delete();
    exp_ev = 0;
    repeat (60) @(posedge clk);
    checkState("post_reset");

    for (int n = 0; n < 40; n++) begin
      applyStimulus(int'($urandom_range(0, 15)), 40 + int'($urandom_range(0, 30)));
      checkState("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
